// File: rtl/aes_rx_block_assembler.sv
// aes_rx_block_assembler: packs uart_rx bytes into one AES plaintext block and offers it over valid/ready.
// Define AES_RX_SKID_EN to hold one byte that arrives while a full block waits, instead of dropping it.
module aes_rx_block_assembler #(
    parameter int NUM_BYTES    = 16,
    parameter int TIMEOUT_CLKS = 8700
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_dv,
    input  logic [7:0]             rx_byte,
    output logic [0:8*NUM_BYTES-1] block_out,
    output logic                   block_valid,
    input  logic                   block_ready,
    output logic [4:0]             byte_count,
    output logic                   overrun,
    output logic                   timeout
);

    // state   | meaning
    // IDLE    | no bytes held, idle timer off
    // COLLECT | partial block held, idle timer running
    // FULL    | complete block offered, waiting for block_ready
    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    localparam int            TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CLKS - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          accept, expire, xfer;

`ifdef AES_RX_SKID_EN
    logic          skid_valid;
    logic [7:0]    skid_byte;
`endif

    assign block_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        expire    = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (rx_dv) begin
                    accept    = 1'b1;
                    state_nxt = (byte_count == 5'(NUM_BYTES - 1)) ? FULL : COLLECT;
                end else if (state == COLLECT && timer == '0) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FULL: begin
                if (block_ready) begin
                    xfer      = 1'b1;
                    state_nxt = IDLE;
`ifdef AES_RX_SKID_EN
                    if (skid_valid || rx_dv) state_nxt = COLLECT;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_out  <= '0;
            byte_count <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            timer      <= '0;
`ifdef AES_RX_SKID_EN
            skid_valid <= 1'b0;
            skid_byte  <= '0;
`endif
        end else begin
            overrun <= 1'b0;
            timeout <= expire;
            if (accept) begin
                block_out[8*byte_count +: 8] <= rx_byte;
                byte_count                   <= byte_count + 5'd1;
                timer                        <= TIMER_LOAD;
            end else if (expire) begin
                byte_count <= '0;
            end else if (state == COLLECT) begin
                timer <= timer - TW'(1);
            end else if (state == FULL) begin
`ifdef AES_RX_SKID_EN
                if (xfer) begin
                    // Parked byte (if any) always goes first so arrival order is kept.
                    skid_valid <= 1'b0;
                    timer      <= TIMER_LOAD;
                    if (skid_valid) begin
                        block_out[0:7] <= skid_byte;
                        if (rx_dv) begin
                            block_out[8:15] <= rx_byte;
                            byte_count      <= 5'd2;
                        end else begin
                            byte_count <= 5'd1;
                        end
                    end else if (rx_dv) begin
                        block_out[0:7] <= rx_byte;
                        byte_count     <= 5'd1;
                    end else begin
                        byte_count <= '0;
                    end
                end else if (rx_dv) begin
                    if (skid_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        skid_valid <= 1'b1;
                        skid_byte  <= rx_byte;
                    end
                end
`else
                if (xfer)  byte_count <= '0;
                if (rx_dv) overrun    <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_rx_block_assembler.sv
// Directed bench for aes_rx_block_assembler: block packing, handshake hold, overrun/skid, timeout, reset.
module tb_aes_rx_block_assembler;

    localparam int TIMEOUT_CLKS = 8700;
    localparam logic [127:0] T1_BLK = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T4_BLK = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_dv;
    logic [7:0]   rx_byte;
    logic [0:127] block_out;
    logic         block_valid;
    logic         block_ready;
    logic [4:0]   byte_count;
    logic         overrun;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_rx_block_assembler #(
        .NUM_BYTES    (16),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .byte_count  (byte_count),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_block(input logic [127:0] blk);
        rx_dv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_byte = blk[127-8*i -: 8];
            tick();
        end
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic seen;
        rst         = 1'b1;
        rx_dv       = 1'b0;
        rx_byte     = 8'h00;
        block_ready = 1'b0;
        #12;
        chk("rst_block", block_out, 128'h0);
        chk("rst_valid", block_valid, 1'b0);
        chk("rst_count", byte_count, 5'd0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T1: ready held high, block appears one clock after the 16th byte
        block_ready = 1'b1;
        send_block(T1_BLK);
        chk("t1_valid", block_valid, 1'b1);
        chk("t1_block", block_out, T1_BLK);
        chk("t1_count", byte_count, 5'd16);
        tick();
        block_ready = 1'b0;
        chk("t1_valid_clr", block_valid, 1'b0);
        chk("t1_count_clr", byte_count, 5'd0);

        // T2: block held stable while ready is low
        send_block(T1_BLK);
        for (int i = 0; i < 20; i++) begin
            chk("t2_hold_block", block_out, T1_BLK);
            chk("t2_hold_count", byte_count, 5'd16);
            chk("t2_hold_valid", block_valid, 1'b1);
            tick();
        end
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("t2_valid_clr", block_valid, 1'b0);
        chk("t2_count_clr", byte_count, 5'd0);

        // T3: extra byte while a full block waits
        send_block(T1_BLK);
        send_byte(8'hAA);
`ifdef AES_RX_SKID_EN
        chk("t3_no_overrun", overrun, 1'b0);
        chk("t3_block_kept", block_out, T1_BLK);
        chk("t3_valid_kept", block_valid, 1'b1);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("t3_skid_valid", block_valid, 1'b0);
        chk("t3_skid_count", byte_count, 5'd1);
        chk("t3_skid_byte", {120'h0, block_out[0:7]}, 128'hAA);
`else
        chk("t3_overrun", overrun, 1'b1);
        chk("t3_block_kept", block_out, T1_BLK);
        chk("t3_count_kept", byte_count, 5'd16);
        tick();
        chk("t3_overrun_end", overrun, 1'b0);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("t3_valid_clr", block_valid, 1'b0);
        chk("t3_count_clr", byte_count, 5'd0);
`endif
        pulse_reset();

        // T4: partial block discarded after TIMEOUT_CLKS idle clocks
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("t4_count5", byte_count, 5'd5);
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT_CLKS - 1; i++) begin
            tick();
            seen |= timeout;
        end
        chk("t4_no_early_timeout", seen, 1'b0);
        chk("t4_count_held", byte_count, 5'd5);
        tick();
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_count_clr", byte_count, 5'd0);
        chk("t4_no_overrun", overrun, 1'b0);
        tick();
        chk("t4_timeout_end", timeout, 1'b0);
        send_block(T4_BLK);
        chk("t4_fresh_block", block_out, T4_BLK);
        chk("t4_fresh_valid", block_valid, 1'b1);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("t4_fresh_clr", byte_count, 5'd0);

        // T5: byte lands on the expiry clock and wins
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
        repeat (TIMEOUT_CLKS - 1) tick();
        send_byte(8'hA6);
        chk("t5_count6", byte_count, 5'd6);
        chk("t5_no_timeout", timeout, 1'b0);
        tick();
        chk("t5_no_timeout_after", timeout, 1'b0);
        chk("t5_count_held", byte_count, 5'd6);

        // T6: async reset at byte_count=7
        send_byte(8'hA7);
        chk("t6_count7", byte_count, 5'd7);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_block", block_out, 128'h0);
        chk("t6_rst_count", byte_count, 5'd0);
        chk("t6_rst_valid", block_valid, 1'b0);
        chk("t6_rst_pulses", {overrun, timeout}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        send_block(T1_BLK);
        chk("t6_block", block_out, T1_BLK);
        chk("t6_valid", block_valid, 1'b1);
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        chk("t6_valid_clr", block_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
